// File: rtl/variable_io_delay.sv
// variable_io_delay
//   Programmable-latency delay line for a bundle of level signals. The input
//   bundle is shifted through a full-depth history every clock; the output is
//   either the live input (cycles == 0) or the history tap selected by cycles.
//
// Ports:
//   clk       - single clock, rising-edge active
//   reset     - synchronous, active-high; clears the whole history
//   cycles    - requested delay N (0..2**CYCLES_W-1), used combinationally
//   original  - undelayed data bundle
//   delayed   - original as sampled N rising edges earlier (N = 0: passthrough)

module variable_io_delay #(
  parameter int WIDTH    = 16,
  parameter int CYCLES_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CYCLES_W-1:0] cycles,
  input  logic [WIDTH-1:0]    original,
  output logic [WIDTH-1:0]    delayed
);

  localparam int unsigned MAX_DELAY = (2 ** CYCLES_W) - 1;

  // hist[k] holds original as sampled k rising edges ago.
  logic [WIDTH-1:0] hist [1:MAX_DELAY];

  // Tap table: index 0 is the live input, so every cycles value selects a
  // valid entry without an out-of-range read.
  logic [WIDTH-1:0] taps [0:MAX_DELAY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
        hist[k] <= '0;
      end
    end else begin
      hist[1] <= original;
      for (int unsigned k = 2; k <= MAX_DELAY; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  always_comb begin
    taps[0] = original;
    for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
      taps[k] = hist[k];
    end
  end

  assign delayed = taps[cycles];

endmodule

// File: tb/tb_variable_io_delay.sv
module tb_variable_io_delay;

  localparam int WIDTH    = 16;
  localparam int CYCLES_W = 4;
  localparam int MAXD     = 15;

  logic                clk = 1'b1;
  logic                reset;
  logic [CYCLES_W-1:0] cycles;
  logic [WIDTH-1:0]    original;
  logic [WIDTH-1:0]    delayed;

  variable_io_delay #(.WIDTH(WIDTH), .CYCLES_W(CYCLES_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cycles   (cycles),
    .original (original),
    .delayed  (delayed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] exp;
    string            name;
  } sb_entry_t;

  sb_entry_t        sb[$];
  logic [WIDTH-1:0] past[$];   // past[0] = most recent sample taken at an edge
  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] cnt;

  // Monitor: compares the output mid-cycle against the scoreboard head.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      checks++;
      if (delayed !== e.exp) begin
        failures++;
        $display("FAIL %s: delayed=%h expected=%h (cycles=%0d original=%h t=%0t)",
                 e.name, delayed, e.exp, cycles, original, $time);
      end
    end
  end

  // Drive one cycle of stimulus, predict the output from the sample history,
  // then advance the history at the rising edge.
  task automatic step(input logic rst, input int n, input logic [WIDTH-1:0] orig,
                      input string name);
    sb_entry_t e;
    reset    = rst;
    cycles   = n[CYCLES_W-1:0];
    original = orig;
    if (n == 0)                e.exp = orig;
    else if (n <= past.size()) e.exp = past[n-1];
    else                       e.exp = '0;
    e.name = name;
    // The first cycle of a reset still shows pre-reset history; not checked.
    if (!(rst && n != 0 && past.size() != 0)) sb.push_back(e);
    @(posedge clk);
    if (rst) past.delete();
    else begin
      past.push_front(orig);
      if (past.size() > MAXD) void'(past.pop_back());
    end
    #1;
  endtask

  initial begin
    // Passthrough during reset, before any clock edge.
    step(1'b1, 0, 16'hA5C3, "pass_a5c3");
    step(1'b1, 0, 16'h1234, "pass_1234");
    // Reset held: tapped output is cleared.
    step(1'b1, 3, 16'hFFFF, "reset_state");
    step(1'b1, 15, 16'hFFFF, "reset_state15");

    // cycles = 3 counter.
    cnt = 1;
    for (int i = 0; i < 20; i++) begin step(1'b0, 3, cnt, "cnt_n3"); cnt++; end

    // cycles = 15 counter after reset.
    step(1'b1, 15, 16'h0, "rst_before_n15");
    step(1'b1, 15, 16'h0, "rst_before_n15");
    cnt = 1;
    for (int i = 0; i < 30; i++) begin step(1'b0, 15, cnt, "cnt_n15"); cnt++; end

    // On-the-fly tap changes on a continuous counter.
    for (int i = 0; i < 20; i++) begin step(1'b0, 2, cnt, "switch_n2"); cnt++; end
    for (int i = 0; i < 10; i++) begin step(1'b0, 7, cnt, "switch_n7"); cnt++; end
    for (int i = 0; i < 5; i++)  begin step(1'b0, 0, cnt, "switch_n0"); cnt++; end

    // Mid-run single-edge reset with cycles = 5.
    for (int i = 0; i < 10; i++) begin step(1'b0, 5, cnt, "mid_n5"); cnt++; end
    step(1'b1, 5, cnt, "mid_reset");
    cnt = 16'h0100;
    for (int i = 0; i < 12; i++) begin step(1'b0, 5, cnt, "post_reset_n5"); cnt++; end

    // Walking one with cycles = 4.
    for (int i = 0; i < 16; i++) step(1'b0, 4, 16'h0001 << i, "walk1_n4");
    for (int i = 0; i < 6; i++)  step(1'b0, 4, 16'h0000, "walk1_tail");

    // Randomized: random data, random tap, occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(39) == 0), $urandom_range(MAXD),
           16'($urandom), "random");
    end

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
